// File: rtl/cheshire_fpga_rst_seq.sv
// FPGA reset/boot sequencer: releases the Cheshire SoC once the PLL is locked, a hold time has
// passed and (with RST_SEQ_DDR_WAIT_EN defined) DRAM calibration is done or timed out.
module cheshire_fpga_rst_seq #(
  parameter int unsigned HoldCycles   = 16,
  parameter int unsigned CalibTimeout = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       test_mode_i,
  input  logic       pll_locked_i,
  input  logic       ext_rst_req_i,
  input  logic       ddr_calib_done_i,
  input  logic [1:0] boot_mode_i,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       calib_timeout_o,
  output logic       seq_busy_o
);

  localparam int unsigned CntMax   = (HoldCycles > CalibTimeout) ? HoldCycles : CalibTimeout;
  localparam int unsigned CntWidth = $clog2(CntMax + 1);
  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HoldCycles - 1);

  typedef enum logic [2:0] {
    StReset,
    StWaitLock,
    StHold,
    StWaitCalib,
    StRun
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]          boot_mode_q, boot_mode_d;
  logic                soc_rst_q;
  logic [1:0]          locked_sync_q, req_sync_q;
  logic                locked_s, req_s, abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_sync_q <= 2'b00;
      req_sync_q    <= 2'b00;
    end else begin
      locked_sync_q <= {locked_sync_q[0], pll_locked_i};
      req_sync_q    <= {req_sync_q[0], ext_rst_req_i};
    end
  end

  assign locked_s = locked_sync_q[1];
  assign req_s    = req_sync_q[1];
  assign abort    = !locked_s || req_s;

`ifdef RST_SEQ_DDR_WAIT_EN
  localparam logic [CntWidth-1:0] CalibLast = CntWidth'(CalibTimeout - 1);

  logic [1:0] calib_sync_q;
  logic       calib_s;
  logic       timeout_q, timeout_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      calib_sync_q <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      calib_sync_q <= {calib_sync_q[0], ddr_calib_done_i};
      timeout_q    <= timeout_d;
    end
  end

  assign calib_s         = calib_sync_q[1];
  assign calib_timeout_o = timeout_q;
`else
  logic unused_ddr_calib;
  assign unused_ddr_calib = ddr_calib_done_i;
  assign calib_timeout_o  = 1'b0;
`endif

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + CntWidth'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_mode_d = boot_mode_q;
`ifdef RST_SEQ_DDR_WAIT_EN
    timeout_d   = timeout_q;
`endif
    case (state_q)
      StReset: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
      StWaitLock: begin
        if (!abort) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          boot_mode_d = boot_mode_i;
          cnt_d       = '0;
`ifdef RST_SEQ_DDR_WAIT_EN
          state_d     = StWaitCalib;
`else
          state_d     = StRun;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
`ifdef RST_SEQ_DDR_WAIT_EN
      StWaitCalib: begin
        if (calib_s) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (cnt_q == CalibLast) begin
          state_d   = StRun;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      StRun: ;
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase

    // Lock loss or external request overrides every other transition, including latching.
    if (state_q != StReset && abort) begin
      state_d     = StWaitLock;
      cnt_d       = '0;
      boot_mode_d = boot_mode_q;
`ifdef RST_SEQ_DDR_WAIT_EN
      timeout_d   = timeout_q;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      boot_mode_q <= 2'b00;
      soc_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boot_mode_q <= boot_mode_d;
      soc_rst_q   <= (state_d == StRun);
    end
  end

  assign soc_rst_no  = test_mode_i ? rst_ni : soc_rst_q;
  assign boot_mode_o = boot_mode_q;
  assign seq_busy_o  = (state_q != StRun);

endmodule

// File: doc/cheshire_fpga_rst_seq.md
# cheshire_fpga_rst_seq

FPGA reset and boot sequencer sitting between the board clock/reset infrastructure (clock wizard lock, board reset button or VIO, DRAM controller calibration) and the Cheshire SoC reset and boot-mode inputs. It replaces the bare reset synchronizer in the Xilinx top level. The SoC is released from reset only after the PLL is locked, a minimum hold time has elapsed and, optionally, DRAM calibration is done. The boot mode is latched once per reset release and held stable while the SoC runs.

## Interface
- `HoldCycles`, 16: number of `clk_i` cycles `soc_rst_no` stays low after lock is seen; ≥ 2.
- `CalibTimeout`, 1_000_000: cycles to wait for DRAM calibration before forcing release; ≥ 1.
- `CntWidth`, `$clog2(max(HoldCycles, CalibTimeout)+1)`: counter width, derived, not overridden.
- `clk_i` input 1: SoC clock (clock wizard output).
- `rst_ni` input 1: asynchronous active-low reset. Power-on/board reset, already inverted to active-low.
- `test_mode_i` input 1: when 1, `soc_rst_no` = `rst_ni` combinationally (DFT bypass).
- `pll_locked_i` input 1: clock wizard lock, asynchronous to `clk_i`.
- `ext_rst_req_i` input 1: asynchronous reset request (VIO/button), active-high, level.
- `ddr_calib_done_i` input 1: DRAM calibration complete, asynchronous.
- `boot_mode_i` input 2: boot mode after switch/VIO mux.
- `soc_rst_no` output 1: SoC reset, active-low, glitch-free flop output.
- `boot_mode_o` output 2: latched boot mode.
- `calib_timeout_o` output 1: sticky. Set when release was forced by timeout.
- `seq_busy_o` output 1: high in any state other than RUN.

## Operation
- Synchronize `pll_locked_i`, `ext_rst_req_i` and `ddr_calib_done_i` through 2-flop synchronizers, each reset to 0. The suffix `_s` below means the synchronized value.
- States and transitions:
  - RESET: entered on `rst_ni` low. Goes to WAIT_LOCK on the first clocked cycle.
  - WAIT_LOCK: waits for `locked_s`=1 and `req_s`=0, then goes to HOLD and clears the counter.
  - HOLD: the counter increments every cycle. At counter == `HoldCycles`-1, the sequencer latches `boot_mode_i` into `boot_mode_o` and goes to WAIT_CALIB, or to RUN when `RST_SEQ_DDR_WAIT_EN` is undefined. The counter clears on this transition.
  - WAIT_CALIB: goes to RUN when `calib_s`=1. If the counter reaches `CalibTimeout`-1 with `calib_s` still 0, it sets `calib_timeout_o` and goes to RUN.
  - RUN: `soc_rst_no`=1.
- Abort: in any state except RESET, `locked_s`=0 or `req_s`=1 sends the FSM to WAIT_LOCK on the next edge. This rule has priority over all other transitions. The counter clears, and `soc_rst_no` goes 0 on that same edge.
- `soc_rst_no` is a flop whose next value is (next state == RUN). There is no combinational path from the FSM state to the output, except the `test_mode_i` mux.
- `boot_mode_o` changes only on the HOLD exit edge. The value is retained across aborts until the next HOLD exit.
- `calib_timeout_o` clears only on `rst_ni`. A later successful calibration does not clear it.
- The counter saturates and never wraps.

## Timing
- Reset values: `soc_rst_no`=0, `boot_mode_o`=0, `calib_timeout_o`=0, `seq_busy_o`=1, FSM=RESET, counter=0.
- Lock-to-release latency is measured from a `pll_locked_i` rise to `soc_rst_no`=1, with calibration already high:
  - 2 sync cycles + 1 (WAIT_LOCK exit) + `HoldCycles` + 1 (WAIT_CALIB exit).
  - With `HoldCycles`=16 this is 20 cycles, or 19 with the macro undefined.
- Abort latency: `soc_rst_no` falls 3 edges after the async input changes (2 sync + 1 state/output flop).
- Simultaneous events: an abort and a HOLD/WAIT_CALIB exit condition on the same cycle result in the abort. In that case `boot_mode_o` is not latched.
- `rst_ni` asserted mid-sequence forces all flops to reset values asynchronously.

## Configuration
- `RST_SEQ_DDR_WAIT_EN` defined:
  - The WAIT_CALIB state exists and `ddr_calib_done_i` is synchronized.
  - The timeout logic is present.
- `RST_SEQ_DDR_WAIT_EN` undefined:
  - HOLD goes directly to RUN.
  - `ddr_calib_done_i` is ignored.
  - `calib_timeout_o` is tied to 0.
  - The timeout counter logic is removed.

## Test plan
- Release latency. Stimulus: `HoldCycles`=16, macro defined, calibration high; release `rst_ni`, then raise `pll_locked_i` at cycle 10. Required: `soc_rst_no` rises exactly 20 cycles later, and `boot_mode_o` equals `boot_mode_i` sampled on the HOLD exit edge.
- Calibration timeout. Stimulus: `CalibTimeout`=1000, `ddr_calib_done_i` held 0. Required: RUN is entered 1000 cycles after entering WAIT_CALIB, `calib_timeout_o`=1, and it stays 1 after calibration later rises.
- Lock loss in RUN. Stimulus: drop `pll_locked_i` for 1 cycle. Required: `soc_rst_no`=0 within 3 edges, followed by a full re-sequence of 20 cycles from lock.
- External request mid-HOLD. Stimulus: pulse `ext_rst_req_i` at HOLD count 8 with `boot_mode_i` changed from 2'b01 to 2'b10. Required: HOLD restarts, and the final `boot_mode_o`=2'b10.
- Test mode and async reset:
  - Stimulus: `test_mode_i`=1 while toggling `rst_ni`. Required: `soc_rst_no` follows `rst_ni` combinationally.
  - Stimulus: `rst_ni` low mid-WAIT_CALIB. Required: all outputs return to reset values immediately.
- Macro undefined. Stimulus: same as the release-latency scenario, with `ddr_calib_done_i`=0. Required: release after 19 cycles, and `calib_timeout_o` stays 0.
